// File: rtl/bus_pkg.sv
// Shared definitions for the bus SRAM slave.
// Contents: bus widths, beat/wait counter widths, the slave FSM state
// encoding and a byte-lane mask helper used by the RAM write path.
package bus_pkg;

  localparam int DATA_W     = 32;
  localparam int BE_W       = 4;
  localparam int BURST_W    = 8;
  localparam int BEAT_CNT_W = 9;
  localparam int WAIT_W     = 4;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD_WAIT  = 3'd1,
    ST_RD_BURST = 3'd2,
    ST_RD_END   = 3'd3,
    ST_WR_BUSY  = 3'd4,
    ST_WR_BEATS = 3'd5,
    ST_ERROR    = 3'd6
  } state_e;

  // Expand one enable bit per byte lane into a full-word bit mask.
  function automatic logic [DATA_W-1:0] be_to_mask(input logic [BE_W-1:0] be);
    logic [DATA_W-1:0] mask;
    mask = {DATA_W{1'b0}};
    for (int b = 0; b < BE_W; b++) begin
      mask[8*b +: 8] = {8{be[b]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/bus_sram_slave_if.sv
// System bus signal bundle as seen by the SRAM slave.
// *In signals are driven by the bus master side, *Out signals by the slave.
// Modports: slave (used by bus_sram_slave), master (used by the driving agent).
interface bus_sram_slave_if;
  import bus_pkg::*;

  logic                beginTransactionIn;
  logic                endTransactionIn;
  logic                readNotWriteIn;
  logic [DATA_W-1:0]   addressDataIn;
  logic [BE_W-1:0]     byteEnablesIn;
  logic [BURST_W-1:0]  burstSizeIn;
  logic                dataValidIn;
  logic                busErrorIn;

  logic [DATA_W-1:0]   addressDataOut;
  logic                dataValidOut;
  logic                endTransactionOut;
  logic                busyOut;
  logic                busErrorOut;

  modport slave (
    input  beginTransactionIn, endTransactionIn, readNotWriteIn, addressDataIn,
           byteEnablesIn, burstSizeIn, dataValidIn, busErrorIn,
    output addressDataOut, dataValidOut, endTransactionOut, busyOut, busErrorOut
  );

  modport master (
    output beginTransactionIn, endTransactionIn, readNotWriteIn, addressDataIn,
           byteEnablesIn, burstSizeIn, dataValidIn, busErrorIn,
    input  addressDataOut, dataValidOut, endTransactionOut, busyOut, busErrorOut
  );

endinterface

// File: rtl/sram_1rw_be.sv
// Single-port synchronous RAM, 2^ADDR_WIDTH x 32, per-byte write enables.
// Ports: clk_i clock; en_i access enable; we_i write (else read);
// be_i byte lanes; addr_i word address; wdata_i write data;
// rdata_o registered read data (valid the cycle after a read access).
// Contents are not reset.
module sram_1rw_be
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk_i,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [BE_W-1:0]       be_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_W-1:0]     wdata_i,
  output logic [DATA_W-1:0]     rdata_o
);

  logic [DATA_W-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] mask_s;

  assign mask_s  = be_to_mask(be_i);
  assign rdata_o = rdata_q;

  // Storage array: masked write or registered read per enabled cycle.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= (mem_q[addr_i] & ~mask_s) | (wdata_i & mask_s);
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

endmodule

// File: rtl/bus_sram_slave.sv
// Word-addressed SRAM slave on the shared system bus.
// Ports: clock system clock; nReset async active-low reset;
// bus (slave modport) carries the begin/end/address-data/beat handshake
// inputs and the wired-OR outputs addressDataOut, dataValidOut,
// endTransactionOut, busyOut, busErrorOut (all zero when not responding).
// Serves single and burst reads/writes in a window of 4*2^ADDR_WIDTH bytes
// at BASE_ADDRESS; word address wraps inside the window.
module bus_sram_slave
  import bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
  parameter int          ADDR_WIDTH   = 10,
  parameter int          WAIT_STATES  = 2
) (
  input  logic            clock,
  input  logic            nReset,
  bus_sram_slave_if.slave bus
);

  // Last wait count before the first read issue, and last busy cycle count.
  localparam logic [WAIT_W-1:0] RD_LAST = WAIT_W'(WAIT_STATES);
  localparam logic [WAIT_W-1:0] WR_LAST = WAIT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   word_q, word_d;
  logic [BEAT_CNT_W-1:0]   beats_q, beats_d;
  logic [WAIT_W-1:0]       wait_q, wait_d;
  logic                    dv_q, dv_d;
  logic                    end_q, end_d;
  logic                    busy_q, busy_d;
  logic                    err_q, err_d;

  logic                    hit_s;
  logic                    ram_en_s;
  logic                    ram_we_s;
  logic [DATA_W-1:0]       ram_rdata_s;

  assign hit_s = (bus.addressDataIn[DATA_W-1:ADDR_WIDTH+2] ==
                  BASE_ADDRESS[DATA_W-1:ADDR_WIDTH+2]);

  sram_1rw_be #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk_i   (clock),
    .en_i    (ram_en_s),
    .we_i    (ram_we_s),
    .be_i    (bus.byteEnablesIn),
    .addr_i  (word_q),
    .wdata_i (bus.addressDataIn),
    .rdata_o (ram_rdata_s)
  );

  // Read data is gated by the registered valid so the wired-OR bus sees zero otherwise.
  assign bus.addressDataOut    = dv_q ? ram_rdata_s : {DATA_W{1'b0}};
  assign bus.dataValidOut      = dv_q;
  assign bus.endTransactionOut = end_q;
  assign bus.busyOut           = busy_q;
  assign bus.busErrorOut       = err_q;

  // State, counters and output registers.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q <= ST_IDLE;
      word_q  <= {ADDR_WIDTH{1'b0}};
      beats_q <= {BEAT_CNT_W{1'b0}};
      wait_q  <= {WAIT_W{1'b0}};
      dv_q    <= 1'b0;
      end_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      beats_q <= beats_d;
      wait_q  <= wait_d;
      dv_q    <= dv_d;
      end_q   <= end_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Next-state, RAM control and next-output decode.
  always_comb begin
    state_d  = state_q;
    word_d   = word_q;
    beats_d  = beats_q;
    wait_d   = wait_q;
    dv_d     = 1'b0;
    end_d    = 1'b0;
    busy_d   = 1'b0;
    err_d    = 1'b0;
    ram_en_s = 1'b0;
    ram_we_s = 1'b0;

    // A bus error from another agent aborts everything with no RAM write.
    if ((state_q != ST_IDLE) && bus.busErrorIn) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.beginTransactionIn && hit_s) begin
            word_d  = bus.addressDataIn[ADDR_WIDTH+1:2];
            beats_d = BEAT_CNT_W'(bus.burstSizeIn) + BEAT_CNT_W'(1'b1);
            wait_d  = {WAIT_W{1'b0}};
            if (bus.addressDataIn[1:0] != 2'b00) begin
              state_d = ST_ERROR;
              err_d   = 1'b1;
            end else if (bus.readNotWriteIn) begin
              state_d = ST_RD_WAIT;
            end else if (WAIT_STATES == 0) begin
              state_d = ST_WR_BEATS;
            end else begin
              state_d = ST_WR_BUSY;
              busy_d  = 1'b1;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end

        // The final wait cycle also issues beat 0, so the first beat
        // lands WAIT_STATES+2 cycles after begin.
        ST_RD_WAIT: begin
          if (wait_q == RD_LAST) begin
            ram_en_s = 1'b1;
            dv_d     = 1'b1;
            word_d   = word_q + ADDR_WIDTH'(1'b1);
            beats_d  = beats_q - BEAT_CNT_W'(1'b1);
            state_d  = (beats_q == BEAT_CNT_W'(1'b1)) ? ST_RD_END : ST_RD_BURST;
          end else begin
            wait_d = wait_q + WAIT_W'(1'b1);
          end
        end

        ST_RD_BURST: begin
          ram_en_s = 1'b1;
          dv_d     = 1'b1;
          word_d   = word_q + ADDR_WIDTH'(1'b1);
          beats_d  = beats_q - BEAT_CNT_W'(1'b1);
          state_d  = (beats_q == BEAT_CNT_W'(1'b1)) ? ST_RD_END : ST_RD_BURST;
        end

        // Last beat is on the bus this cycle; the end pulse follows it.
        ST_RD_END: begin
          end_d   = 1'b1;
          state_d = ST_IDLE;
        end

        // Beats offered while busy are ignored; the master holds them.
        ST_WR_BUSY: begin
          if (bus.endTransactionIn) begin
            state_d = ST_IDLE;
          end else if (wait_q == WR_LAST) begin
            state_d = ST_WR_BEATS;
          end else begin
            busy_d = 1'b1;
            wait_d = wait_q + WAIT_W'(1'b1);
          end
        end

        // Beats past the latched count are dropped; end may coincide with a beat.
        ST_WR_BEATS: begin
          if (bus.dataValidIn && (beats_q != {BEAT_CNT_W{1'b0}})) begin
            ram_en_s = 1'b1;
            ram_we_s = 1'b1;
            word_d   = word_q + ADDR_WIDTH'(1'b1);
            beats_d  = beats_q - BEAT_CNT_W'(1'b1);
          end else begin
            beats_d = beats_q;
          end
          if (bus.endTransactionIn) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_WR_BEATS;
          end
        end

        ST_ERROR: begin
          state_d = ST_IDLE;
        end

        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

endmodule
